// File: rtl/fused_tensor_serializer_pkg.sv
// Shared constants and types for the fused tensor output stream.
package fusion_stream_pkg;

    localparam int FRAME_WORDS   = 135;
    localparam int HDR_WORDS     = 2;
    localparam int TS_WORDS      = 4;
    localparam int PAYLOAD_WORDS = 128;

    localparam logic [15:0] HDR_MAGIC_DFLT = 16'hF05E;

    typedef logic [15:0] fusion_word_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_TSTAMP,
        S_PAYLOAD,
        S_CHECKSUM
    } ser_state_t;

endpackage

// File: rtl/fused_tensor_serializer_if.sv
// Valid/ready word stream from the serializer toward the host/DMA link.
interface fused_tensor_serializer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fused_tensor_serializer_hold_slot.sv
// Single-entry tensor + timestamp register. Load wins over take so a slot
// can be drained and refilled in the same cycle.
module tensor_hold_slot #(
    parameter int TENSOR_WIDTH = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    take_i,
    input  logic [TENSOR_WIDTH-1:0] tensor_i,
    input  logic [63:0]             ts_i,
    output logic                    full_o,
    output logic [TENSOR_WIDTH-1:0] tensor_o,
    output logic [63:0]             ts_o
);
    logic                    full_q;
    logic [TENSOR_WIDTH-1:0] tensor_q;
    logic [63:0]             ts_q;

    // Occupancy flag and captured contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= 1'b0;
            tensor_q <= '0;
            ts_q     <= '0;
        end else if (load_i) begin
            full_q   <= 1'b1;
            tensor_q <= tensor_i;
            ts_q     <= ts_i;
        end else if (take_i) begin
            full_q   <= 1'b0;
        end
    end

    assign full_o   = full_q;
    assign tensor_o = tensor_q;
    assign ts_o     = ts_q;
endmodule

// File: rtl/fused_tensor_serializer.sv
// Frames each fused tensor as magic/seq/timestamp/payload/checksum words on a
// valid/ready stream. One tensor can wait in a pending slot; further arrivals
// during a frame are dropped and counted.
module fused_tensor_serializer
    import fusion_stream_pkg::*;
#(
    parameter int           TENSOR_WIDTH = 2048,
    parameter int           WORD_WIDTH   = 16,
    parameter fusion_word_t HDR_MAGIC    = HDR_MAGIC_DFLT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TENSOR_WIDTH-1:0]   tensor_in,
    input  logic                      tensor_valid,
    input  logic [63:0]               timestamp_in,
    fused_tensor_serializer_if.master m_if,
    output logic                      busy,
    output logic [7:0]                drop_count,
    output logic                      overflow
);
    localparam int         NUM_ELEMS = TENSOR_WIDTH / WORD_WIDTH;
    localparam int         PW        = $clog2(NUM_ELEMS);
    localparam logic [7:0] TS_FIRST  = 8'(HDR_WORDS);
    localparam logic [7:0] PAY_FIRST = 8'(HDR_WORDS + TS_WORDS);
    localparam logic [7:0] PAY_LAST  = 8'(HDR_WORDS + TS_WORDS + NUM_ELEMS - 1);

    ser_state_t   state_q, state_d;
    logic [7:0]   idx_q, idx_d;
    fusion_word_t seq_q, seq_d;
    fusion_word_t frame_seq_q, frame_seq_d;
    fusion_word_t csum_q, csum_d;
    logic [7:0]   drop_q, drop_d;

    logic                    act_full, pend_full;
    logic [TENSOR_WIDTH-1:0] act_tensor, pend_tensor;
    logic [63:0]             act_ts, pend_ts;

    logic                    hs, last_hs, start, drop;
    logic                    act_load, pend_load, pend_take;
    logic [TENSOR_WIDTH-1:0] act_src_tensor;
    logic [63:0]             act_src_ts;
    fusion_word_t            word;
    logic [1:0]              ts_sel;
    logic [PW-1:0]           pay_sel;

    // Start/capture/drop decisions: pending tensor always goes first.
    always_comb begin
        hs        = m_if.m_valid && m_if.m_ready;
        last_hs   = hs && (state_q == S_CHECKSUM);
        start     = ((state_q == S_IDLE) || last_hs) && (pend_full || tensor_valid);
        act_load  = start;
        pend_take = start && pend_full;
        pend_load = tensor_valid && (start ? pend_full : !pend_full);
        drop      = tensor_valid && !start && pend_full;
        act_src_tensor = pend_full ? pend_tensor : tensor_in;
        act_src_ts     = pend_full ? pend_ts     : timestamp_in;
    end

    tensor_hold_slot #(.TENSOR_WIDTH(TENSOR_WIDTH)) u_active (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (act_load),
        .take_i   (last_hs),
        .tensor_i (act_src_tensor),
        .ts_i     (act_src_ts),
        .full_o   (act_full),
        .tensor_o (act_tensor),
        .ts_o     (act_ts)
    );

    tensor_hold_slot #(.TENSOR_WIDTH(TENSOR_WIDTH)) u_pending (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (pend_load),
        .take_i   (pend_take),
        .tensor_i (tensor_in),
        .ts_i     (timestamp_in),
        .full_o   (pend_full),
        .tensor_o (pend_tensor),
        .ts_o     (pend_ts)
    );

    // Output word selected from the frame index; zero while idle.
    always_comb begin
        ts_sel  = 2'(PAY_FIRST - 8'd1 - idx_q);
        pay_sel = PW'(idx_q - PAY_FIRST);
        word    = '0;
        unique case (state_q)
            S_HEADER:   word = (idx_q == 8'd0) ? HDR_MAGIC : frame_seq_q;
            S_TSTAMP:   word = act_ts[ts_sel*16 +: 16];
            S_PAYLOAD:  word = act_tensor[pay_sel*WORD_WIDTH +: WORD_WIDTH];
            S_CHECKSUM: word = csum_q;
            default:    word = '0;
        endcase
    end

    // Next-state: index/checksum advance on handshake, start overrides.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        frame_seq_d = frame_seq_q;
        csum_d      = csum_q;
        drop_d      = drop_q;
        if (hs) begin
            idx_d = idx_q + 8'd1;
            if (idx_q != 8'd0 && state_q != S_CHECKSUM)
                csum_d = csum_q + word;
            unique case (state_q)
                S_HEADER:   if (idx_q == TS_FIRST - 8'd1)  state_d = S_TSTAMP;
                S_TSTAMP:   if (idx_q == PAY_FIRST - 8'd1) state_d = S_PAYLOAD;
                S_PAYLOAD:  if (idx_q == PAY_LAST)         state_d = S_CHECKSUM;
                S_CHECKSUM: state_d = S_IDLE;
                default:    state_d = state_q;
            endcase
        end
        if (start) begin
            state_d     = S_HEADER;
            idx_d       = 8'd0;
            csum_d      = '0;
            frame_seq_d = seq_q;
            seq_d       = seq_q + 16'd1;
        end
        if (drop && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    // FSM, counters and checksum registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 8'd0;
            seq_q       <= '0;
            frame_seq_q <= '0;
            csum_q      <= '0;
            drop_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            seq_q       <= seq_d;
            frame_seq_q <= frame_seq_d;
            csum_q      <= csum_d;
            drop_q      <= drop_d;
        end
    end

    assign m_if.m_data  = word;
    assign m_if.m_valid = (state_q != S_IDLE);
    assign m_if.m_last  = (state_q == S_CHECKSUM);
    assign busy         = (state_q != S_IDLE) || act_full || pend_full;
    assign drop_count   = drop_q;
    assign overflow     = drop;
endmodule

// File: tb/tb_fused_tensor_serializer.sv
// Directed + randomized bench; expected frames come from a queue-based model.
module tb_fused_tensor_serializer;
    localparam int TW = 2048;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] tensor_in = '0;
    logic          tensor_valid = 1'b0;
    logic [63:0]   timestamp_in = '0;
    logic          busy, overflow;
    logic [7:0]    drop_count;

    fused_tensor_serializer_if #(.WORD_WIDTH(16)) sif ();

    fused_tensor_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tensor_in    (tensor_in),
        .tensor_valid (tensor_valid),
        .timestamp_in (timestamp_in),
        .m_if         (sif),
        .busy         (busy),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    int          rdy_mode = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    longint      got_cyc[$];
    logic [15:0] mseq = 16'd0;
    logic        stall_prev = 1'b0;
    logic [17:0] held = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Record every word that will be accepted at the next edge; check stall stability.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev)
                chk("stall_hold", {sif.m_valid, sif.m_last, sif.m_data}, held);
            if (sif.m_valid && sif.m_ready) begin
                got_q.push_back({sif.m_last, sif.m_data});
                got_cyc.push_back(cyc);
            end
        end
        stall_prev = rst_n && sif.m_valid && !sif.m_ready;
        held = {1'b1, sif.m_last, sif.m_data};
    end

    // Sink ready pattern.
    initial begin
        sif.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: sif.m_ready = 1'b1;
                1: sif.m_ready = ~sif.m_ready;
                2: sif.m_ready = 1'($urandom_range(0, 1));
                default: sif.m_ready = 1'b0;
            endcase
        end
    end

    // Reference frame: magic, seq, timestamp high-to-low, elements, mod-2^16 sum.
    task automatic add_frame(input logic [TW-1:0] t, input logic [63:0] ts);
        logic [15:0] sum;
        logic [15:0] w;
        sum = mseq;
        exp_q.push_back({1'b0, 16'hF05E});
        exp_q.push_back({1'b0, mseq});
        for (int k = 3; k >= 0; k--) begin
            w = ts[16*k +: 16];
            sum += w;
            exp_q.push_back({1'b0, w});
        end
        for (int e = 0; e < TW / 16; e++) begin
            w = t[16*e +: 16];
            sum += w;
            exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, sum});
        mseq++;
    endtask

    function automatic logic [TW-1:0] rand_tensor();
        logic [TW-1:0] r;
        for (int i = 0; i < TW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic pulse(input logic [TW-1:0] t, input logic [63:0] ts);
        tensor_in = t;
        timestamp_in = ts;
        tensor_valid = 1'b1;
        @(posedge clk);
        #1;
        tensor_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((busy || got_q.size() != exp_q.size()) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, 64'(n < 3000), 64'd1);
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic flush();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [TW-1:0] ramp, ta, tb, tc;
        logic [63:0]   ts0;
        int            n, ovf_cnt;

        for (int i = 0; i < TW / 16; i++) ramp[16*i +: 16] = 16'(i);
        ts0 = 64'h0001_0002_0003_0004;

        // Reset state
        #12;
        chk("rst_valid", sif.m_valid, 0);
        chk("rst_last", sif.m_last, 0);
        chk("rst_data", sif.m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drops", drop_count, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ramp tensor, ready held high; latency and frame length
        chk("t1_pre_valid", sif.m_valid, 0);
        add_frame(ramp, ts0);
        pulse(ramp, ts0);
        @(negedge clk);
        chk("t1_lat_valid", sif.m_valid, 1);
        chk("t1_lat_w0", sif.m_data, 16'hF05E);
        wait_done("t1");
        if (got_cyc.size() >= 135) chk("t1_duration", 64'(got_cyc[134] - got_cyc[0]), 64'd134);
        flush();

        // Same tensor with ready toggling
        rdy_mode = 1;
        add_frame(ramp, ts0);
        pulse(ramp, ts0);
        wait_done("t2");
        flush();
        rdy_mode = 0;
        @(posedge clk); #1;

        // Pulses at 0/10/20: send, pend, drop
        ta = rand_tensor(); tb = rand_tensor(); tc = rand_tensor();
        add_frame(ta, 64'hA);
        add_frame(tb, 64'hB);
        pulse(ta, 64'hA);
        repeat (9) @(posedge clk); #1;
        pulse(tb, 64'hB);
        repeat (9) @(posedge clk); #1;
        tensor_in = tc; timestamp_in = 64'hC; tensor_valid = 1'b1;
        @(negedge clk);
        chk("t3_ovf", overflow, 1);
        chk("t3_busy", busy, 1);
        @(posedge clk); #1; tensor_valid = 1'b0;
        @(negedge clk);
        chk("t3_ovf_once", overflow, 0);
        chk("t3_drops", drop_count, 1);
        wait_done("t3");
        if (got_cyc.size() >= 136) chk("t3_b2b", 64'(got_cyc[135] - got_cyc[134]), 64'd1);
        flush();

        // Arrival on the w134 handshake with pending full
        ta = rand_tensor(); tb = rand_tensor(); tc = rand_tensor();
        add_frame(ta, 64'h1111);
        add_frame(tb, 64'h2222);
        add_frame(tc, 64'h3333);
        pulse(ta, 64'h1111);
        repeat (3) @(posedge clk); #1;
        pulse(tb, 64'h2222);
        n = 0;
        @(negedge clk);
        while (!(sif.m_valid && sif.m_last && sif.m_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t4_found_last", 64'(n < 400), 64'd1);
        tensor_in = tc; timestamp_in = 64'h3333; tensor_valid = 1'b1;
        #1;
        chk("t4_no_ovf", overflow, 0);
        @(posedge clk); #1; tensor_valid = 1'b0;
        wait_done("t4");
        chk("t4_drops", drop_count, 1);
        flush();

        // Reset mid-frame at word 60
        add_frame(rand_tensor(), 64'h5);
        pulse(ramp, 64'h5);
        n = 0;
        while (got_q.size() < 60 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach60", 64'(n < 400), 64'd1);
        #2; rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", sif.m_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_last", sif.m_last, 0);
        chk("t5_rst_drops", drop_count, 0);
        repeat (2) @(posedge clk); #1; rst_n = 1'b1;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        mseq = 16'd0;
        repeat (5) @(posedge clk); #1;
        chk("t5_quiet", 64'(got_q.size()), 64'd0);
        chk("t5_idle_valid", sif.m_valid, 0);
        ta = rand_tensor();
        add_frame(ta, 64'hDEAD_BEEF_0000_0001);
        pulse(ta, 64'hDEAD_BEEF_0000_0001);
        wait_done("t5");
        if (got_q.size() > 1) chk("t5_seq0", got_q[1], 17'h0);
        flush();

        // Random tensors under random ready
        rdy_mode = 2;
        ta = rand_tensor(); tb = rand_tensor();
        add_frame(ta, {$urandom, $urandom});
        add_frame(tb, 64'h77);
        pulse(ta, {exp_q[2][15:0], exp_q[3][15:0], exp_q[4][15:0], exp_q[5][15:0]});
        pulse(tb, 64'h77);
        wait_done("t6");
        flush();

        // 300 drops with the sink stalled
        rdy_mode = 3;
        @(posedge clk); #1;
        ta = rand_tensor(); tb = rand_tensor();
        add_frame(ta, 64'h10);
        add_frame(tb, 64'h20);
        pulse(ta, 64'h10);
        pulse(tb, 64'h20);
        ovf_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tensor_in = rand_tensor(); timestamp_in = 64'(i); tensor_valid = 1'b1;
            @(negedge clk);
            if (overflow) ovf_cnt++;
            @(posedge clk); #1;
        end
        tensor_valid = 1'b0;
        chk("t7_ovf_pulses", 64'(ovf_cnt), 64'd300);
        chk("t7_drops_sat", drop_count, 8'd255);
        rdy_mode = 0;
        wait_done("t7");
        chk("t7_drops_hold", drop_count, 8'd255);
        flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
